alu_seq: RTL

Multi-cycle execution unit that consumes the decoded ALU controls (operation select, subtract, unsigned, arithmetic) together with two operands, and returns a registered result through a valid/ready handshake. It is the consumer end of the ALU decode interface. It is intended for the multi-cycle datapath variant, where shifts iterate one bit per cycle unless the fast shifter is compiled in.

---
 rtl/alu_if.sv | 28 ++
 rtl/alu_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/alu_if.sv
// Request/response bundle between the ALU decode stage and the multi-cycle execution unit.
interface alu_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            i_valid;
  logic            o_ready;
  logic [XLEN-1:0] i_op1;
  logic [XLEN-1:0] i_op2;
  logic [2:0]      i_opsel;
  logic            i_sub;
  logic            i_unsigned;
  logic            i_arith;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_result;
  logic            o_eq;
  logic            o_lt;

  modport master (
    output i_valid, i_op1, i_op2, i_opsel, i_sub, i_unsigned, i_arith, i_ready,
    input  o_ready, o_valid, o_result, o_eq, o_lt
  );

  modport slave (
    input  i_valid, i_op1, i_op2, i_opsel, i_sub, i_unsigned, i_arith, i_ready,
    output o_ready, o_valid, o_result, o_eq, o_lt
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle ALU with valid/ready handshake. Shifts iterate one bit per cycle unless
// ALU_FAST_SHIFT_EN is defined, which selects a single-cycle barrel shifter.
module alu_seq #(
  parameter int unsigned XLEN = 32
) (
  input logic  i_clk,
  input logic  i_rst,
  alu_if.slave bus
);
  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            eq_q, eq_d;
  logic            lt_q, lt_d;

  logic [XLEN-1:0] op1, op2;
  logic [SHW-1:0]  shamt;
  logic            is_shift;
  logic            eq_now, lt_now;
  logic [XLEN-1:0] alu_res;

  assign op1      = bus.i_op1;
  assign op2      = bus.i_op2;
  assign shamt    = op2[SHW-1:0];
  assign is_shift = (bus.i_opsel == 3'b001) || (bus.i_opsel == 3'b101);
  assign eq_now   = (op1 == op2);
  assign lt_now   = bus.i_unsigned ? (op1 < op2) : ($signed(op1) < $signed(op2));

  always_comb begin
    alu_res = op1;
    case (bus.i_opsel)
      3'b000:  alu_res = bus.i_sub ? (op1 - op2) : (op1 + op2);
      3'b010,
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_now};
      3'b100:  alu_res = op1 ^ op2;
      3'b110:  alu_res = op1 | op2;
      3'b111:  alu_res = op1 & op2;
`ifdef ALU_FAST_SHIFT_EN
      3'b001:  alu_res = op1 << shamt;
      3'b101:  alu_res = bus.i_arith ? XLEN'($signed(op1) >>> shamt) : (op1 >> shamt);
`endif
      default: alu_res = op1;
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [XLEN-1:0] shreg_q, shreg_d;
  logic [SHW-1:0]  cnt_q, cnt_d;
  logic            left_q, left_d;
  logic            arith_q, arith_d;
  logic [XLEN-1:0] shifted;

  // sra replicates the MSB only when the latched arith flag is set.
  assign shifted = left_q ? {shreg_q[XLEN-2:0], 1'b0}
                          : {arith_q & shreg_q[XLEN-1], shreg_q[XLEN-1:1]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    eq_d     = eq_q;
    lt_d     = lt_q;
`ifndef ALU_FAST_SHIFT_EN
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    arith_d  = arith_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.i_valid) begin
          eq_d = eq_now;
          lt_d = lt_now;
`ifdef ALU_FAST_SHIFT_EN
          result_d = alu_res;
          state_d  = StDone;
`else
          if (is_shift) begin
            shreg_d = op1;
            cnt_d   = shamt;
            left_d  = (bus.i_opsel == 3'b001);
            arith_d = bus.i_arith;
            if (shamt == '0) begin
              result_d = op1;
              state_d  = StDone;
            end else begin
              state_d = StShift;
            end
          end else begin
            result_d = alu_res;
            state_d  = StDone;
          end
`endif
        end
      end
      StShift: begin
`ifdef ALU_FAST_SHIFT_EN
        state_d = StIdle;
`else
        shreg_d = shifted;
        cnt_d   = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d = shifted;
          state_d  = StDone;
        end
`endif
      end
      StDone: begin
        if (bus.i_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      result_q <= '0;
      eq_q     <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      eq_q     <= eq_d;
      lt_q     <= lt_d;
    end
  end

  assign bus.o_ready  = (state_q == StIdle);
  assign bus.o_valid  = (state_q == StDone);
  assign bus.o_result = result_q;
  assign bus.o_eq     = eq_q;
  assign bus.o_lt     = lt_q;
endmodule
